// File: rtl/simd_alu_adder_arb.sv
// ---------------------------------------------------------------------------
// simd_alu_adder_arb
//
// Round-robin scheduler that shares one external combinational SIMD adder
// among NUM_REQ requesters.
//
// Pipeline:
//   S1 (issue)  : holds the winning operation. Its registers drive the adder
//                 inputs directly and keep their value when S1 empties.
//   S2 (output) : captures the adder result and overflow, tagged with the
//                 requester id.
// Output back-pressure stalls both stages without losing an operation.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready [NUM_REQ]   per-requester handshake (one-hot ready)
//   req_a/req_b                     operands, requester i at slice i
//   req_data_mode                   2 bits per requester (0=8b..3=64b lanes)
//   req_data_signed/req_sub         per-requester signedness / subtract
//   adder_a/b/data_mode/
//     data_signed/sub               registered drive to the shared adder
//   adder_result/adder_ovf          combinational response from the adder
//   out_valid/out_ready             result handshake
//   out_id/out_result/out_ovf       result payload
//   ovf_sticky/ovf_clr              sticky per-requester overflow status
//
// Optional feature:
//   SIMD_ADDER_ARB_OVF_STICKY_EN    when defined, ovf_sticky[i] is set by any
//                                   result for requester i with a nonzero
//                                   overflow vector and cleared by ovf_clr[i].
//                                   When undefined, ovf_sticky is constant 0.
// ---------------------------------------------------------------------------
module simd_alu_adder_arb #(
  parameter int SIMD_DATA_WIDTH = 256,
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*SIMD_DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*SIMD_DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]           req_data_mode,
  input  logic [NUM_REQ-1:0]             req_data_signed,
  input  logic [NUM_REQ-1:0]             req_sub,
  output logic [SIMD_DATA_WIDTH-1:0]     adder_a,
  output logic [SIMD_DATA_WIDTH-1:0]     adder_b,
  output logic [1:0]                     adder_data_mode,
  output logic                           adder_data_signed,
  output logic                           adder_sub,
  input  logic [SIMD_DATA_WIDTH-1:0]     adder_result,
  input  logic [SIMD_DATA_WIDTH/8-1:0]   adder_ovf,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ID_W-1:0]                out_id,
  output logic [SIMD_DATA_WIDTH-1:0]     out_result,
  output logic [SIMD_DATA_WIDTH/8-1:0]   out_ovf,
  output logic [NUM_REQ-1:0]             ovf_sticky,
  input  logic [NUM_REQ-1:0]             ovf_clr
);

  localparam int W     = SIMD_DATA_WIDTH;
  localparam int OVF_W = SIMD_DATA_WIDTH / 8;

  // S1 issue register
  logic                 s1_v_q;
  logic [ID_W-1:0]      s1_id_q;
  logic [W-1:0]         s1_a_q, s1_b_q;
  logic [1:0]           s1_mode_q;
  logic                 s1_signed_q, s1_sub_q;

  // S2 output register
  logic                 s2_v_q;
  logic [ID_W-1:0]      s2_id_q;
  logic [W-1:0]         s2_res_q;
  logic [OVF_W-1:0]     s2_ovf_q;

  // Round-robin pointer
  logic [ID_W-1:0]      ptr_q, ptr_d;

  // Arbitration
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_found;
  int                   sel;
  int                   idx;

  logic                 s1_load, s2_load, accept;

  assign s2_load = s1_v_q & (~s2_v_q | out_ready);
  assign s1_load = ~s1_v_q | s2_load;
  assign accept  = grant_found & s1_load;

  // NOTE: every variable written here gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    idx         = 0;
    // Search upward from ptr with wrap; first valid requester wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  assign sel   = int'(grant_id);
  assign ptr_d = (sel == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

  // Gating with rst_n keeps req_ready at 0 while reset is held even when
  // requesters are already asserting valid.
  assign req_ready = grant & {NUM_REQ{s1_load & rst_n}};

  // NOTE: state is updated with non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  // NOTE: the operand/payload registers are reset too, because they drive
  // output ports whose reset value must be 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      s1_v_q      <= 1'b0;
      s1_id_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= '0;
      s1_signed_q <= 1'b0;
      s1_sub_q    <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_id_q     <= '0;
      s2_res_q    <= '0;
      s2_ovf_q    <= '0;
    end else begin
      // S1: refill when free or draining; payload is kept when nothing is
      // accepted so the adder inputs stay quiet.
      if (s1_load) begin
        s1_v_q <= accept;
        if (accept) begin
          ptr_q       <= ptr_d;
          s1_id_q     <= grant_id;
          s1_a_q      <= req_a[sel*W +: W];
          s1_b_q      <= req_b[sel*W +: W];
          s1_mode_q   <= req_data_mode[sel*2 +: 2];
          s1_signed_q <= req_data_signed[sel];
          s1_sub_q    <= req_sub[sel];
        end
      end
      // S2: capture the adder response for the op currently in S1.
      if (s2_load) begin
        s2_v_q   <= 1'b1;
        s2_id_q  <= s1_id_q;
        s2_res_q <= adder_result;
        s2_ovf_q <= adder_ovf;
      end else if (out_ready) begin
        s2_v_q   <= 1'b0;
      end
    end
  end

  assign adder_a           = s1_a_q;
  assign adder_b           = s1_b_q;
  assign adder_data_mode   = s1_mode_q;
  assign adder_data_signed = s1_signed_q;
  assign adder_sub         = s1_sub_q;

  assign out_valid  = s2_v_q;
  assign out_id     = s2_id_q;
  assign out_result = s2_res_q;
  assign out_ovf    = s2_ovf_q;

`ifdef SIMD_ADDER_ARB_OVF_STICKY_EN
  logic [NUM_REQ-1:0] sticky_q;
  logic [NUM_REQ-1:0] sticky_set;

  // Set is applied after clear, so a simultaneous set wins.
  always_comb begin
    sticky_set = '0;
    if (s2_load && (|adder_ovf)) sticky_set[s1_id_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_q & ~ovf_clr) | sticky_set;
    end
  end

  assign ovf_sticky = sticky_q;
`else
  // Feature disabled: constant 0; the AND keeps ovf_clr referenced while
  // still reducing to a tie-off.
  assign ovf_sticky = ovf_clr & {NUM_REQ{1'b0}};
`endif

endmodule

// File: tb/tb_simd_alu_adder_arb.sv
// ---------------------------------------------------------------------------
// tb_simd_alu_adder_arb
//
// Self-checking bench for simd_alu_adder_arb. The shared SIMD adder is
// modelled here with plain per-lane arithmetic and connected to the DUT's
// adder ports. A cycle-level reference of the arbiter/pipeline predicts
// req_ready and every output, and directed steps cover the single-request,
// round-robin, back-pressure, 64b wrap, mid-operation reset and sticky
// overflow scenarios. Build with +define+SIMD_ADDER_ARB_OVF_STICKY_EN to
// exercise the sticky feature.
// ---------------------------------------------------------------------------
module tb_simd_alu_adder_arb;

  localparam int W   = 256;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int OW  = W / 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid, req_ready;
  logic [N*W-1:0]     req_a, req_b;
  logic [N*2-1:0]     req_data_mode;
  logic [N-1:0]       req_data_signed, req_sub;
  logic [W-1:0]       adder_a, adder_b, adder_result;
  logic [1:0]         adder_data_mode;
  logic               adder_data_signed, adder_sub;
  logic [OW-1:0]      adder_ovf;
  logic               out_valid, out_ready;
  logic [IDW-1:0]     out_id;
  logic [W-1:0]       out_result;
  logic [OW-1:0]      out_ovf;
  logic [N-1:0]       ovf_sticky, ovf_clr;

  always #5 clk = ~clk;

  simd_alu_adder_arb #(.SIMD_DATA_WIDTH(W), .NUM_REQ(N), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_data_mode(req_data_mode),
    .req_data_signed(req_data_signed), .req_sub(req_sub),
    .adder_a(adder_a), .adder_b(adder_b), .adder_data_mode(adder_data_mode),
    .adder_data_signed(adder_data_signed), .adder_sub(adder_sub),
    .adder_result(adder_result), .adder_ovf(adder_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_result(out_result), .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  // Behavioural SIMD adder: lane-wise add/sub; per-byte overflow in mode 0
  // (signed range for signed ops, carry/borrow for unsigned), 0 otherwise.
  function automatic logic [W+OW-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [1:0] mode, input logic sgn,
                                              input logic sub);
    logic [W-1:0]  res;
    logic [OW-1:0] ovf;
    logic [63:0]   mask, x, y, av, bv, rv;
    int            w, r, ai, bi;
    res  = '0;
    ovf  = '0;
    w    = 8 << mode;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int c = 0; c < W / 64; c++) begin
      x = a[c*64 +: 64];
      y = b[c*64 +: 64];
      for (int k = 0; k < 64 / w; k++) begin
        av = (x >> (k * w)) & mask;
        bv = (y >> (k * w)) & mask;
        rv = (sub ? av - bv : av + bv) & mask;
        res[c*64 +: 64] = res[c*64 +: 64] | (rv << (k * w));
      end
    end
    if (mode == 2'd0) begin
      for (int i = 0; i < OW; i++) begin
        if (sgn) begin
          ai = int'($signed(a[i*8 +: 8]));
          bi = int'($signed(b[i*8 +: 8]));
        end else begin
          ai = int'(a[i*8 +: 8]);
          bi = int'(b[i*8 +: 8]);
        end
        r = sub ? ai - bi : ai + bi;
        ovf[i] = sgn ? (r > 127 || r < -128) : (r > 255 || r < 0);
      end
    end
    return {res, ovf};
  endfunction

  assign {adder_result, adder_ovf} =
    ref_add(adder_a, adder_b, adder_data_mode, adder_data_signed, adder_sub);

  // Reference model state
  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   a, b;
    logic [1:0]     mode;
    logic           sgn, sub;
  } op_t;

  int             m_ptr;
  logic           m_s1_v, m_s2_v;
  op_t            m_s1;
  logic [IDW-1:0] m_s2_id;
  logic [W-1:0]   m_s2_res;
  logic [OW-1:0]  m_s2_ovf;
  logic [N-1:0]   m_sticky;

  int checks = 0;
  int errors = 0;
  int acc_ids[$];
  int consumed = 0;
  int last_acc = -1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_s1_v   = 1'b0;
    m_s1     = '{id: '0, a: '0, b: '0, mode: '0, sgn: 1'b0, sub: 1'b0};
    m_s2_v   = 1'b0;
    m_s2_id  = '0;
    m_s2_res = '0;
    m_s2_ovf = '0;
    m_sticky = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, W'(req_ready), '0);
    check({tag, "_adder_a"}, adder_a, '0);
    check({tag, "_adder_b"}, adder_b, '0);
    check({tag, "_adder_ctl"}, W'({adder_data_mode, adder_data_signed, adder_sub}), '0);
    check({tag, "_out_valid"}, W'(out_valid), '0);
    check({tag, "_out_id"}, W'(out_id), '0);
    check({tag, "_out_result"}, out_result, '0);
    check({tag, "_out_ovf"}, W'(out_ovf), '0);
    check({tag, "_ovf_sticky"}, W'(ovf_sticky), '0);
  endtask

  // One clock cycle: compare everything against the model, then advance the
  // model across the rising edge. Entered and left 1 time unit after an edge.
  task automatic tick();
    int            g;
    logic [N-1:0]  exp_ready;
    logic          s1_load, s2_load;
    logic [W+OW-1:0] r;
    op_t           n_s1;
    logic          n_s1_v, n_s2_v;
    logic [N-1:0]  n_sticky;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (g < 0 && req_valid[i]) g = i;
    end
    s2_load   = m_s1_v && (!m_s2_v || out_ready);
    s1_load   = !m_s1_v || s2_load;
    exp_ready = '0;
    if (g >= 0 && s1_load) exp_ready[g] = 1'b1;

    check("req_ready", W'(req_ready), W'(exp_ready));
    check("adder_a", adder_a, m_s1.a);
    check("adder_b", adder_b, m_s1.b);
    check("adder_ctl", W'({adder_data_mode, adder_data_signed, adder_sub}),
          W'({m_s1.mode, m_s1.sgn, m_s1.sub}));
    check("out_valid", W'(out_valid), W'(m_s2_v));
    check("out_id", W'(out_id), W'(m_s2_id));
    check("out_result", out_result, m_s2_res);
    check("out_ovf", W'(out_ovf), W'(m_s2_ovf));
    check("ovf_sticky", W'(ovf_sticky), W'(m_sticky));

    if (m_s2_v && out_ready) consumed++;
    last_acc = (exp_ready != '0) ? g : -1;
    if (last_acc >= 0) acc_ids.push_back(g);

    r        = ref_add(m_s1.a, m_s1.b, m_s1.mode, m_s1.sgn, m_s1.sub);
    n_s1     = m_s1;
    n_s1_v   = m_s1_v;
    n_s2_v   = m_s2_v;
    n_sticky = '0;
`ifdef SIMD_ADDER_ARB_OVF_STICKY_EN
    n_sticky = m_sticky & ~ovf_clr;
    if (s2_load && (|r[OW-1:0])) n_sticky[m_s1.id] = 1'b1;
`endif
    if (s1_load) begin
      n_s1_v = (g >= 0);
      if (g >= 0) begin
        n_s1.id   = IDW'(g);
        n_s1.a    = req_a[g*W +: W];
        n_s1.b    = req_b[g*W +: W];
        n_s1.mode = req_data_mode[g*2 +: 2];
        n_s1.sgn  = req_data_signed[g];
        n_s1.sub  = req_sub[g];
      end
    end

    @(posedge clk);
    if (s2_load) begin
      n_s2_v   = 1'b1;
      m_s2_id  = m_s1.id;
      m_s2_res = r[W+OW-1:OW];
      m_s2_ovf = r[OW-1:0];
    end else if (out_ready) begin
      n_s2_v = 1'b0;
    end
    if (g >= 0 && s1_load) m_ptr = (g + 1) % N;
    m_s1     = n_s1;
    m_s1_v   = n_s1_v;
    m_s2_v   = n_s2_v;
    m_sticky = n_sticky;
    #1;
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] mode, input logic sgn, input logic sub);
    req_a[i*W +: W]        = a;
    req_b[i*W +: W]        = b;
    req_data_mode[i*2 +: 2] = mode;
    req_data_signed[i]     = sgn;
    req_sub[i]             = sub;
  endtask

  task automatic rand_req(input int i);
    set_req(i, rand_vec(), rand_vec(), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear at once.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_out(input string tag, input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, W'(out_valid), W'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, cons0;
    logic exp_st;
    rst_n           = 1'b0;
    req_valid       = '0;
    req_a           = '0;
    req_b           = '0;
    req_data_mode   = '0;
    req_data_signed = '0;
    req_sub         = '0;
    out_ready       = 1'b0;
    ovf_clr         = '0;
    model_reset();
`ifdef SIMD_ADDER_ARB_OVF_STICKY_EN
    exp_st = 1'b1;
`else
    exp_st = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single request: 8b unsigned 0x01 + 0xFF in every byte
    set_req(0, {32{8'h01}}, {32{8'hFF}}, 2'd0, 1'b0, 1'b0);
    req_valid = 4'b0001;
    out_ready = 1'b1;
    tick();
    check("single_accepted", W'(acc_ids.size()), W'(1));
    req_valid = '0;
    check("single_lat1", W'(out_valid), W'(1'b0));
    tick();
    check("single_lat2", W'(out_valid), W'(1'b1));
    check("single_id", W'(out_id), W'(0));
    check("single_result", out_result, '0);
    check("single_ovf", W'(out_ovf), W'({OW{1'b1}}));
    tick();

    // Round robin: all requesters valid, fresh payload after each accept
    pulse_reset("rr_reset");
    for (int i = 0; i < N; i++) rand_req(i);
    req_valid = '1;
    acc_ids.delete();
    for (int c = 0; c < 12; c++) begin
      tick();
      if (last_acc >= 0) rand_req(last_acc);
    end
    check("rr_count", W'(acc_ids.size()), W'(12));
    for (int k = 0; k < 12; k++) check("rr_order", W'(acc_ids[k]), W'(k % N));
    req_valid = '0;
    repeat (3) tick();

    // Back-pressure: req1 streams 16b signed 5 - 7 while out_ready is low
    out_ready = 1'b0;
    set_req(1, {16{16'h0005}}, {16{16'h0007}}, 2'd1, 1'b1, 1'b1);
    req_valid = 4'b0010;
    acc0  = acc_ids.size();
    cons0 = consumed;
    repeat (5) tick();
    check("bp_accepts", W'(acc_ids.size() - acc0), W'(2));
    check("bp_ready_low", W'(req_ready), '0);
    check("bp_valid", W'(out_valid), W'(1'b1));
    check("bp_result", out_result, {16{16'hFFFE}});
    out_ready = 1'b1;
    repeat (4) tick();
    req_valid = '0;
    repeat (3) tick();
    check("bp_no_loss", W'(consumed - cons0), W'(acc_ids.size() - acc0));

    // 64b signed wrap
    set_req(3, {4{64'h7FFF_FFFF_FFFF_FFFF}}, {4{64'd1}}, 2'd3, 1'b1, 1'b0);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    wait_out("wrap", 5);
    check("wrap_result", out_result, {4{64'h8000_0000_0000_0000}});
    check("wrap_ovf", W'(out_ovf), '0);
    tick();

    // Reset mid-operation with both stages full
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) rand_req(i);
    req_valid = '1;
    repeat (3) tick();
    check("mid_full", W'(out_valid), W'(1'b1));
    pulse_reset("mid_reset");
    out_ready = 1'b1;
    acc_ids.delete();
    tick();
    check("mid_first_count", W'(acc_ids.size()), W'(1));
    check("mid_first_id", W'(acc_ids[0]), W'(0));
    req_valid = '0;
    repeat (3) tick();

    // Sticky overflow: req2 signed 0x7F + 0x01
    set_req(2, {32{8'h7F}}, {32{8'h01}}, 2'd0, 1'b1, 1'b0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (2) tick();
    check("sticky_set", W'(ovf_sticky[2]), W'(exp_st));
    set_req(2, {32{8'h01}}, {32{8'h01}}, 2'd0, 1'b1, 1'b0);
    req_valid = 4'b0100;
    repeat (3) tick();
    req_valid = '0;
    repeat (2) tick();
    check("sticky_hold", W'(ovf_sticky[2]), W'(exp_st));
    ovf_clr = 4'b0100;
    tick();
    ovf_clr = '0;
    check("sticky_clear", W'(ovf_sticky[2]), W'(1'b0));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_alu_adder_arb.md
# simd_alu_adder_arb

Round-robin scheduler that shares one `simd_alu_adder_top` instance among `NUM_REQ` requesters. It drives the adder's operand and mode inputs from a registered issue stage. It captures the adder's combinational `result`/`ovf` into an output register tagged with the winning requester's index. Valid/ready handshakes are used on both sides, and output back-pressure stalls the pipeline without loss.

## Interface
- `SIMD_DATA_WIDTH`, default 256: lane vector width; must be a multiple of 64.
- `NUM_REQ`, default 4: number of requesters, 1..16.
- `ID_W`, default `max(1, $clog2(NUM_REQ))`: requester index width.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `req_valid  in  NUM_REQ`: per-requester operation valid.
- `req_ready  out  NUM_REQ`: per-requester accept; at most one bit high.
- `req_a`, `req_b  in  NUM_REQ*SIMD_DATA_WIDTH`: operands, requester i at slice i.
- `req_data_mode  in  NUM_REQ*2`: 0=8b, 1=16b, 2=32b, 3=64b lanes.
- `req_data_signed`, `req_sub  in  NUM_REQ`: signedness and subtract select.
- `adder_a`, `adder_b  out  SIMD_DATA_WIDTH`: to adder `a`/`b`.
- `adder_data_mode  out  2`, `adder_data_signed  out  1`, `adder_sub  out  1`: to adder.
- `adder_result  in  SIMD_DATA_WIDTH`, `adder_ovf  in  SIMD_DATA_WIDTH/8`: from adder.
- `out_valid  out  1`, `out_ready  in  1`: result handshake.
- `out_id  out  ID_W`, `out_result  out  SIMD_DATA_WIDTH`, `out_ovf  out  SIMD_DATA_WIDTH/8`: result payload.
- `ovf_sticky  out  NUM_REQ`, `ovf_clr  in  NUM_REQ`: sticky overflow status (see Configuration).

## Operation
- **Two-stage pipeline.**
  - S1 issue register: valid bit, operands, mode, signed, sub, id.
  - S2 output register: valid bit, result, ovf, id.
- **Adder drive.** Adder inputs are driven continuously from S1. When S1 is empty they hold their last values; no toggling is required.
- **Stage advance.**
  - `s2_load = s1_v & (~s2_v | out_ready)`.
  - `s1_load = ~s1_v | s2_load`.
- **Arbitration.**
  - Round-robin pointer `ptr` (reset 0). The grant goes to the first i with `req_valid[i]`, searching from `ptr` upward with wrap.
  - `req_ready[i] = grant[i] & s1_load`.
  - On accept, `ptr <= granted+1`, wrapping at `NUM_REQ`. With no accept, `ptr` holds.
- **Handshake rules.**
  - A requester must hold its payload stable while valid and not ready.
  - A non-granted requester is never readied.
  - Dropping `req_valid` before accept is permitted; the grant recomputes the same cycle.
- **Output capture.** `out_result`/`out_ovf` are captured unmodified from the adder while S1 holds the operation. `out_ovf` is meaningful only for mode 0; other modes yield 0 from the adder and are passed as-is.
- **Output hold.** While `out_valid & ~out_ready`, all `out_*` signals hold stable.
- **Reset.** Asserting `rst_n` low mid-operation discards both stages immediately. Nothing is replayed.
- **Reset values.** All outputs reset to 0: `req_ready`, `adder_*`, `out_valid`, `out_id`, `out_result`, `out_ovf`, `ovf_sticky`.

## Timing
- **Latency.** Request accepted at edge T, S1 loaded at T. Result registered at T+1, `out_valid` high after T+1: two cycles accept-to-valid.
- **Throughput.** One operation per cycle while `out_ready` stays high.
- **Full pipeline.** With S1 and S2 full and `out_ready` low, every `req_ready` is 0.
- **Draining.** Raising `out_ready` frees S2 and S1 in the same edge. Any granted request is therefore accepted in that cycle.
- **Combinational paths.**
  - Only `req_valid` → `req_ready`, and `out_ready` → `req_ready`.
  - No combinational path from `adder_result` to any output port.
- **Adder timing.** The adder is combinational; its full propagation must fit in one `clk` period.

## Configuration
- **Macro `SIMD_ADDER_ARB_OVF_STICKY_EN`.**
- **Defined:** `ovf_sticky[i]` sets on the edge S2 loads an op with id i and nonzero `|adder_ovf`.
  - `ovf_clr[i]` clears the bit.
  - Set wins over simultaneous clear.
  - The bit remains set until cleared.
- **Undefined:** `ovf_sticky` is tied to 0 and `ovf_clr` is ignored. No sticky flops are synthesized.

## Test plan
- **Single request.** `rst_n` released; req0 issues 8b unsigned 0x01+0xFF in every byte, `out_ready`=1.
  - `out_valid` is high 2 cycles after accept.
  - `out_id`=0, result bytes 0x00, `out_ovf` all-ones.
- **Round robin.** All 4 requesters hold valid with `out_ready`=1.
  - Accept order is 0,1,2,3,0,… with one accept per cycle.
  - `out_id` follows 2 cycles later.
- **Back-pressure.** Hold `out_ready`=0 for 5 cycles with req1 streaming 16b signed subtract 0x0005−0x0007.
  - After two accepts, `req_ready` is 0.
  - Outputs hold 0xFFFE lanes.
  - On release, no op is lost or duplicated.
- **64b signed wrap.** Issue 0x7FFF…FF + 1 in mode 3, signed → lane result 0x8000…00.
- **Reset mid-operation.** Pulse `rst_n` low while S1/S2 are full → all outputs are 0 immediately and `ptr` returns to 0.
- **Sticky overflow (with `SIMD_ADDER_ARB_OVF_STICKY_EN`).** Req2 issues signed 0x7F+0x01.
  - `ovf_sticky[2]`=1 and remains 1 after further clean ops.
  - `ovf_clr[2]` pulse clears it.
  - Without the macro, the bit stays 0.
